// File: rtl/msum3_pkg.sv
// Shared types and constants for the 3-sample moving-sum decoder.
package msum3_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIFF = 2'd1,
        S_ADD  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    localparam logic [2:0] F_SUB = 3'd0;
    localparam logic [2:0] F_ADD = 3'd1;

endpackage

// File: rtl/msum3_if.sv
// Sum-in / sample-out stream bundle; master is the environment, slave is the decoder.
interface msum3_if
    import msum3_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    localparam int SW = WIDTH + 2;

    logic             in_valid;
    logic             in_ready;
    logic [SW-1:0]    in_sum;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_d;

    modport master (
        output in_valid, in_sum, out_ready,
        input  in_ready, out_valid, out_d
    );

    modport slave (
        input  in_valid, in_sum, out_ready,
        output in_ready, out_valid, out_d
    );
endinterface

// File: rtl/msum3_alu.sv
// Combinational add/sub unit shared by both decode steps; the only adder in the block.
module msum3_alu
    import msum3_pkg::*;
#(
    parameter int SW = WIDTH_DEF + 2
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic [2:0]    f,
    output logic [SW-1:0] result
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default, otherwise an unlisted code infers a latch.
        result = '0;
        case (f)
            F_SUB:   result = a - b;
            F_ADD:   result = a + b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/msum3_dec.sv
// Moving-sum decoder: d[n] = s[n] - s[n-1] + d[n-3], two ALU passes per sample.
// Optional MSUM_DEC_CHK_EN adds a sticky err flag for out-of-range recovered samples.
module msum3_dec
    import msum3_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic   clk,
    input  logic   rstn,
    msum3_if.slave bus,
    output logic   busy,
    output logic   err
);

    localparam int SW = WIDTH + 2;

    state_t        state;
    logic [SW-1:0] s_cur;
    logic [SW-1:0] s_prev;
    logic [SW-1:0] h1;
    logic [SW-1:0] h2;
    logic [SW-1:0] h3;
    logic [SW-1:0] acc;

    logic [SW-1:0] alu_a;
    logic [SW-1:0] alu_b;
    logic [2:0]    alu_f;
    logic [SW-1:0] alu_res;

    always_comb begin
        alu_a = s_cur;
        alu_b = s_prev;
        alu_f = F_SUB;
        if (state == S_ADD) begin
            alu_a = acc;
            alu_b = h3;
            alu_f = F_ADD;
        end
    end

    msum3_alu #(.SW(SW)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .f      (alu_f),
        .result (alu_res)
    );

    // Sum/history registers reset to zero: that is the all-zero stream preceding the first sample.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= S_IDLE;
            s_cur  <= '0;
            s_prev <= '0;
            h1     <= '0;
            h2     <= '0;
            h3     <= '0;
            acc    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        s_cur <= bus.in_sum;
                        state <= S_DIFF;
                    end
                end
                S_DIFF: begin
                    acc   <= alu_res;
                    state <= S_ADD;
                end
                S_ADD: begin
                    acc   <= alu_res;
                    state <= S_OUT;
                end
                S_OUT: begin
                    // History advances only on the output handshake.
                    if (bus.out_ready) begin
                        h3     <= h2;
                        h2     <= h1;
                        h1     <= acc;
                        s_prev <= s_cur;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Gating with rstn keeps in_ready low while reset is held even though the FSM already sits in S_IDLE.
    assign bus.in_ready  = rstn && (state == S_IDLE);
    assign bus.out_valid = (state == S_OUT);
    assign bus.out_d     = acc[WIDTH-1:0];
    assign busy          = (state != S_IDLE);

`ifdef MSUM_DEC_CHK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if (state == S_ADD && alu_res[SW-1:WIDTH] != '0) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_msum3_dec.sv
// Directed bench for msum3_dec: vector table plus hand-written backpressure, reset and streaming cases.
module tb_msum3_dec;
    import msum3_pkg::*;

    localparam int WIDTH = 8;
    localparam int SW    = WIDTH + 2;

`ifdef MSUM_DEC_CHK_EN
    localparam logic EXP_CHK_ERR = 1'b1;
`else
    localparam logic EXP_CHK_ERR = 1'b0;
`endif

    typedef struct {
        logic          do_reset;
        logic [SW-1:0] sum;
        logic [7:0]    exp_d;
        logic          exp_err;
        string         name;
    } vec_t;

    logic clk;
    logic rstn;
    logic busy;
    logic err;

    int total = 0;
    int bad   = 0;

    msum3_if #(.WIDTH(WIDTH)) bus ();

    msum3_dec #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave),
        .busy (busy),
        .err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("rst in_ready",  32'(bus.in_ready),  0);
        check("rst out_valid", 32'(bus.out_valid), 0);
        check("rst out_d",     32'(bus.out_d),     0);
        check("rst busy",      32'(busy),          0);
        check("rst err",       32'(err),           0);
        rstn = 1'b1;
        @(negedge clk);
        check("post-rst in_ready", 32'(bus.in_ready), 1);
    endtask

    // One sample through the block with out_ready=1; ends at the negedge after the handshake.
    task automatic xfer(input logic [SW-1:0] s, input logic [7:0] exp_d, input string nm);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({nm, " ready wait"}, 32'(n < 50), 1);
        bus.in_valid = 1'b1;
        bus.in_sum   = s;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({nm, " latency"}, 32'(n), 3);
        check({nm, " out_d"}, 32'(bus.out_d), 32'(exp_d));
        @(negedge clk);
    endtask

    vec_t vecs[$];

    initial begin
        int            n;
        int            in_idx;
        int            out_idx;
        int            last_acc;
        int            acc_cnt;
        logic          adv;
        logic [7:0]    held;
        logic [SW-1:0] bb_sum [6];
        logic [7:0]    bb_d   [6];

        vecs.push_back('{1'b1, 10'd3,   8'd3,   1'b0,        "basic0"});
        vecs.push_back('{1'b0, 10'd8,   8'd5,   1'b0,        "basic1"});
        vecs.push_back('{1'b0, 10'd15,  8'd7,   1'b0,        "basic2"});
        vecs.push_back('{1'b0, 10'd14,  8'd2,   1'b0,        "basic3"});
        vecs.push_back('{1'b1, 10'd255, 8'd255, 1'b0,        "wide0"});
        vecs.push_back('{1'b0, 10'd510, 8'd255, 1'b0,        "wide1"});
        vecs.push_back('{1'b0, 10'd765, 8'd255, 1'b0,        "wide2"});
        vecs.push_back('{1'b0, 10'd510, 8'd0,   1'b0,        "wide3"});
        vecs.push_back('{1'b1, 10'd300, 8'd44,  EXP_CHK_ERR, "chk0"});
        vecs.push_back('{1'b0, 10'd300, 8'd0,   EXP_CHK_ERR, "chk1"});
        vecs.push_back('{1'b0, 10'd600, 8'd44,  EXP_CHK_ERR, "chk2"});

        bus.in_valid  = 1'b0;
        bus.in_sum    = '0;
        bus.out_ready = 1'b1;
        rstn          = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].do_reset) do_reset();
            xfer(vecs[i].sum, vecs[i].exp_d, vecs[i].name);
            check({vecs[i].name, " err"}, 32'(err), 32'(vecs[i].exp_err));
        end

        // Backpressure: first sample stalls in S_OUT, then the stream continues as the basic case.
        do_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_sum    = 10'd3;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp latency", 32'(n), 3);
        held = bus.out_d;
        check("bp out_d", 32'(held), 3);
        bus.in_valid = 1'b1;
        bus.in_sum   = 10'd99;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp hold out_valid", 32'(bus.out_valid), 1);
            check("bp hold out_d",     32'(bus.out_d),     32'(held));
            check("bp hold in_ready",  32'(bus.in_ready),  0);
            check("bp hold busy",      32'(busy),          1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp single handshake", 32'(bus.out_valid), 0);
        check("bp back idle",        32'(bus.in_ready),  1);
        xfer(10'd8,  8'd5, "bp next1");
        xfer(10'd15, 8'd7, "bp next2");
        xfer(10'd14, 8'd2, "bp next3");

        // Reset pulse while the FSM is in S_ADD.
        bus.in_valid = 1'b1;
        bus.in_sum   = 10'd50;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("mid busy before rst", 32'(busy), 1);
        rstn = 1'b0;
        #1;
        check("mid rst in_ready",  32'(bus.in_ready),  0);
        check("mid rst out_valid", 32'(bus.out_valid), 0);
        check("mid rst out_d",     32'(bus.out_d),     0);
        check("mid rst busy",      32'(busy),          0);
        check("mid rst err",       32'(err),           0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        xfer(10'd9, 8'd9, "after mid rst");

        // Back-to-back: in_valid held high over six sums of the stream 10,20,...,60.
        do_reset();
        bb_sum = '{10'd10, 10'd30, 10'd60, 10'd90, 10'd120, 10'd150};
        bb_d   = '{8'd10,  8'd20,  8'd30,  8'd40,  8'd50,   8'd60};
        in_idx   = 0;
        out_idx  = 0;
        last_acc = -1;
        acc_cnt  = 0;
        adv      = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sum   = bb_sum[0];
        for (int cyc = 0; cyc < 60 && out_idx < 6; cyc++) begin
            if (adv) begin
                adv = 1'b0;
                in_idx++;
                if (in_idx < 6) bus.in_sum = bb_sum[in_idx];
                else bus.in_valid = 1'b0;
            end
            if (bus.in_valid && bus.in_ready) begin
                if (last_acc >= 0) check("b2b accept spacing", 32'(cyc - last_acc), 4);
                last_acc = cyc;
                acc_cnt++;
                adv = 1'b1;
            end
            if (bus.out_valid) begin
                check("b2b out_d", 32'(bus.out_d), 32'(bb_d[out_idx]));
                out_idx++;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("b2b accepts", 32'(acc_cnt), 6);
        check("b2b outputs", 32'(out_idx), 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
